// File: rtl/array_pkg.sv
// Shared defaults and FSM encoding for the array_edge_feeder block.
// The optional statistics counters are enabled with ARRAY_EDGE_FEEDER_STATS_EN.
package array_pkg;

   localparam int DEFAULT_ROWS   = 4;
   localparam int DEFAULT_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } feeder_state_t;

endpackage

// File: rtl/skew_line.sv
// DEPTH-stage data+valid shift register; one instance delays one array lane.
// It advances every cycle and never stalls.
module skew_line #(
   parameter int DEPTH  = 1,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid
);

   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [DEPTH-1:0]  valid_q;
   logic [DEPTH-1:0]  valid_d;

   always_comb begin
      valid_d   = '0;
      data_d[0] = in_data;
      valid_d[0] = in_valid;
      for (int i = 1; i < DEPTH; i++) begin
         data_d[i]  = data_q[i-1];
         valid_d[i] = valid_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
         end
         valid_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= data_d[i];
         end
         valid_q <= valid_d;
      end
   end

   assign out_data  = data_q[DEPTH-1];
   assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/array_edge_feeder.sv
// Left-edge feeder for a systolic array: accepts row vectors and skews lane r by r cycles.
// Optional beat/bubble counters are enabled with ARRAY_EDGE_FEEDER_STATS_EN.
module array_edge_feeder
   import array_pkg::*;
#(
   parameter int ROWS   = DEFAULT_ROWS,
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ROWS*DATA_W-1:0] in_data,
   input  logic                   in_last,
   output logic [ROWS*DATA_W-1:0] out_data,
   output logic [ROWS-1:0]        out_valid,
`ifdef ARRAY_EDGE_FEEDER_STATS_EN
   output logic [31:0]            stat_beats,
   output logic [31:0]            stat_bubbles,
`endif
   output logic [1:0]             dbg_state,
   output logic                   busy
);

   localparam int CNT_W = (ROWS > 2) ? $clog2(ROWS) : 1;

   feeder_state_t          state_q, state_d;
   logic [CNT_W-1:0]       drain_cnt_q, drain_cnt_d;
   logic                   accept;
   logic [ROWS*DATA_W-1:0] lane_in;

   // Handshake: a vector transfers on a cycle where in_valid && in_ready.
   // in_ready depends on state only; upstream holds in_valid/in_data until it transfers.
   assign in_ready  = (state_q != DRAIN);
   assign accept    = in_valid && in_ready;
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;
   assign lane_in   = accept ? in_data : '0;

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      unique case (state_q)
         IDLE, STREAM: begin
            if (accept) begin
               if (in_last) begin
                  state_d     = DRAIN;
                  drain_cnt_d = CNT_W'(ROWS - 1);
               end else begin
                  state_d = STREAM;
               end
            end
         end
         DRAIN: begin
            drain_cnt_d = drain_cnt_q - CNT_W'(1);
            if (drain_cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            drain_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   // Lane r has r+1 stages, so the wavefront reaches row r one cycle after row r-1.
   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      skew_line #(
         .DEPTH  (r + 1),
         .DATA_W (DATA_W)
      ) u_lane (
         .clk       (clk),
         .reset     (reset),
         .in_data   (lane_in[r*DATA_W +: DATA_W]),
         .in_valid  (accept),
         .out_data  (out_data[r*DATA_W +: DATA_W]),
         .out_valid (out_valid[r])
      );
   end

`ifdef ARRAY_EDGE_FEEDER_STATS_EN
   logic [31:0] beats_q, beats_d;
   logic [31:0] bubbles_q, bubbles_d;

   always_comb begin
      beats_d   = beats_q;
      bubbles_d = bubbles_q;
      if (accept) begin
         beats_d = beats_q + 32'd1;
      end else if (state_q == STREAM) begin
         bubbles_d = bubbles_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         beats_q   <= '0;
         bubbles_q <= '0;
      end else begin
         beats_q   <= beats_d;
         bubbles_q <= bubbles_d;
      end
   end

   assign stat_beats   = beats_q;
   assign stat_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_array_edge_feeder.sv
// Randomized self-checking bench for array_edge_feeder against a cycle-history model.
module tb_array_edge_feeder;
   import array_pkg::*;

   localparam int ROWS   = 4;
   localparam int DATA_W = 16;
   localparam int VW     = ROWS * DATA_W;
   localparam int MAXC   = 2048;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [VW-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic [VW-1:0] out_data;
   logic [ROWS-1:0] out_valid;
   logic [1:0]    dbg_state;
   logic          busy;
`ifdef ARRAY_EDGE_FEEDER_STATS_EN
   logic [31:0]   stat_beats;
   logic [31:0]   stat_bubbles;
   int            m_beats = 0;
   int            m_bubbles = 0;
`endif

   int checks = 0;
   int errors = 0;

   // Model: every cycle's accepted vector is logged; lane r at cycle c shows the log at c-1-r.
   logic [VW-1:0] vec_hist [MAXC];
   bit            acc_hist [MAXC];
   int            cyc = 0;
   int            reset_cyc = -1;
   int            drain_end = -1;
   bit            streaming = 0;

   array_edge_feeder #(.ROWS(ROWS), .DATA_W(DATA_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .out_data     (out_data),
      .out_valid    (out_valid),
`ifdef ARRAY_EDGE_FEEDER_STATS_EN
      .stat_beats   (stat_beats),
      .stat_bubbles (stat_bubbles),
`endif
      .dbg_state    (dbg_state),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   function automatic bit m_ready();
      return !(cyc <= drain_end);
   endfunction

   function automatic bit m_busy();
      return streaming || (cyc <= drain_end);
   endfunction

   function automatic logic [1:0] m_state();
      if (streaming) return STREAM;
      if (cyc <= drain_end) return DRAIN;
      return IDLE;
   endfunction

   function automatic logic [ROWS-1:0] exp_valid();
      logic [ROWS-1:0] v;
      v = '0;
      for (int r = 0; r < ROWS; r++) begin
         int s;
         s = cyc - 1 - r;
         if (s >= 0 && s > reset_cyc) v[r] = acc_hist[s];
      end
      return v;
   endfunction

   function automatic logic [VW-1:0] exp_data();
      logic [VW-1:0] d;
      d = '0;
      for (int r = 0; r < ROWS; r++) begin
         int s;
         s = cyc - 1 - r;
         if (s >= 0 && s > reset_cyc && acc_hist[s]) d[r*DATA_W +: DATA_W] = vec_hist[s][r*DATA_W +: DATA_W];
      end
      return d;
   endfunction

   // Drives one cycle of inputs, advances the clock and the model, and returns #1 after the edge.
   task automatic step(input logic v, input logic [VW-1:0] d, input logic l, input logic rst);
      bit acc;
      if (cyc >= MAXC - 1) begin
         $display("FAIL cycle_budget: cyc %0d, limit %0d", cyc, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      reset = rst; in_valid = v; in_data = d; in_last = l;
      acc = v && !rst && m_ready();
      acc_hist[cyc] = acc;
      vec_hist[cyc] = d;
`ifdef ARRAY_EDGE_FEEDER_STATS_EN
      if (acc) m_beats++;
      else if (m_state() == STREAM) m_bubbles++;
`endif
      @(posedge clk);
      if (rst) begin
         reset_cyc = cyc; streaming = 0; drain_end = -1;
`ifdef ARRAY_EDGE_FEEDER_STATS_EN
         m_beats = 0; m_bubbles = 0;
`endif
      end else if (acc) begin
         if (l) begin streaming = 0; drain_end = cyc + ROWS - 1; end
         else streaming = 1;
      end
      cyc++;
      #1;
   endtask

   task automatic test_reset();
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (out_data !== '0 || out_valid !== '0 || in_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== IDLE) begin
         errors++;
         $display("FAIL reset_state: data %h valid %b ready %b busy %b state %0d, expected 0 0 1 0 0",
                  out_data, out_valid, in_ready, busy, dbg_state);
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b0, VW'($urandom), 1'b0, 1'b0);
         checks++;
         if (out_data !== '0 || out_valid !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle cyc%0d: data %h valid %b ready %b busy %b, expected 0 0 1 0",
                     cyc, out_data, out_valid, in_ready, busy);
         end
      end
   endtask

   task automatic test_single();
      logic [VW-1:0] d;
      d = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
      step(1'b1, d, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         if (i > 0) step(1'b0, '0, 1'b0, 1'b0);
         checks++;
         if (out_data !== exp_data() || out_valid !== exp_valid()) begin
            errors++;
            $display("FAIL single_lanes t+%0d: data %h valid %b, expected %h %b", i + 1, out_data, out_valid, exp_data(), exp_valid());
         end
         checks++;
         if (in_ready !== m_ready() || busy !== m_busy() || dbg_state !== m_state()) begin
            errors++;
            $display("FAIL single_ctrl t+%0d: ready %b busy %b state %0d, expected %b %b %0d",
                     i + 1, in_ready, busy, dbg_state, m_ready(), m_busy(), m_state());
         end
         if (i == 3) begin
            checks++;
            if (out_data[63:48] !== 16'h0004 || out_valid !== 4'b1000 || busy !== 1'b0 || in_ready !== 1'b1) begin
               errors++;
               $display("FAIL single_t4: lane3 %h valid %b busy %b ready %b, expected 0004 1000 0 1",
                        out_data[63:48], out_valid, busy, in_ready);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int low_cnt;
      low_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         logic [VW-1:0] d;
         for (int r = 0; r < ROWS; r++) d[r*DATA_W +: DATA_W] = DATA_W'(16 * k + r);
         step(1'b1, d, (k == 4), 1'b0);
         checks++;
         if (out_data !== exp_data() || out_valid !== exp_valid() || in_ready !== m_ready() || busy !== m_busy()) begin
            errors++;
            $display("FAIL b2b_feed k%0d: data %h valid %b ready %b busy %b, expected %h %b %b %b",
                     k, out_data, out_valid, in_ready, busy, exp_data(), exp_valid(), m_ready(), m_busy());
         end
         if (!in_ready) low_cnt++;
      end
      for (int i = 0; i < 6; i++) begin
         step(1'b0, '0, 1'b0, 1'b0);
         checks++;
         if (out_data !== exp_data() || out_valid !== exp_valid() || in_ready !== m_ready() || busy !== m_busy()) begin
            errors++;
            $display("FAIL b2b_drain i%0d: data %h valid %b ready %b busy %b, expected %h %b %b %b",
                     i, out_data, out_valid, in_ready, busy, exp_data(), exp_valid(), m_ready(), m_busy());
         end
         if (!in_ready) low_cnt++;
      end
      checks++;
      if (low_cnt !== ROWS - 1) begin
         errors++;
         $display("FAIL b2b_drain_len: %0d cycles, expected %0d", low_cnt, ROWS - 1);
      end
   endtask

   task automatic test_bubbles();
      bit v_seq [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 11; i++) begin
         if (i < 5) step(v_seq[i], VW'({$urandom, $urandom}), (i == 4), 1'b0);
         else step(1'b0, '0, 1'b0, 1'b0);
         checks++;
         if (out_data !== exp_data() || out_valid !== exp_valid() || in_ready !== m_ready() || dbg_state !== m_state()) begin
            errors++;
            $display("FAIL bubble i%0d: data %h valid %b ready %b state %0d, expected %h %b %b %0d",
                     i, out_data, out_valid, in_ready, dbg_state, exp_data(), exp_valid(), m_ready(), m_state());
         end
      end
   endtask

   task automatic test_backpressure();
      logic [VW-1:0] held;
      int waited;
      bit got;
      held = VW'({$urandom, $urandom});
      step(1'b1, VW'({$urandom, $urandom}), 1'b1, 1'b0);
      waited = 0;
      got = 0;
      while (!got && waited < 10) begin
         step(1'b1, held, 1'b1, 1'b0);
         got = acc_hist[cyc-1];
         waited++;
         checks++;
         if (out_data !== exp_data() || out_valid !== exp_valid() || in_ready !== m_ready() || busy !== m_busy()) begin
            errors++;
            $display("FAIL bp_hold w%0d: data %h valid %b ready %b busy %b, expected %h %b %b %b",
                     waited, out_data, out_valid, in_ready, busy, exp_data(), exp_valid(), m_ready(), m_busy());
         end
      end
      checks++;
      if (waited !== ROWS) begin
         errors++;
         $display("FAIL bp_accept_cycle: accepted after %0d held cycles, expected %0d", waited, ROWS);
      end
      for (int i = 0; i < 7; i++) begin
         step(1'b0, '0, 1'b0, 1'b0);
         checks++;
         if (out_data !== exp_data() || out_valid !== exp_valid() || in_ready !== m_ready() || busy !== m_busy()) begin
            errors++;
            $display("FAIL bp_flush i%0d: data %h valid %b ready %b busy %b, expected %h %b %b %b",
                     i, out_data, out_valid, in_ready, busy, exp_data(), exp_valid(), m_ready(), m_busy());
         end
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, VW'({$urandom, $urandom}), 1'b0, 1'b0);
      step(1'b1, VW'({$urandom, $urandom}), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
      checks++;
      if (out_data !== '0 || out_valid !== '0 || dbg_state !== IDLE || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: data %h valid %b state %0d busy %b ready %b, expected 0 0 0 0 1",
                  out_data, out_valid, dbg_state, busy, in_ready);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, '0, 1'b0, 1'b0);
         checks++;
         if (out_valid !== '0 || out_data !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stale i%0d: data %h valid %b busy %b, expected 0 0 0", i, out_data, out_valid, busy);
         end
      end
   endtask

   task automatic test_random();
      bit            pend;
      logic [VW-1:0] pd;
      logic          pl;
      pend = 0; pd = '0; pl = 0;
      for (int i = 0; i < 320; i++) begin
         bit v;
         if (i >= 300) begin
            v = 0; pend = 0;
         end else if (!pend) begin
            v  = ($urandom_range(0, 3) != 0);
            pd = VW'({$urandom, $urandom});
            pl = ($urandom_range(0, 7) == 0);
         end else begin
            v = 1;
         end
         step(v, pd, pl, 1'b0);
         pend = v && !acc_hist[cyc-1];
         checks++;
         if (out_data !== exp_data() || out_valid !== exp_valid() || in_ready !== m_ready()
             || busy !== m_busy() || dbg_state !== m_state()) begin
            errors++;
            $display("FAIL random i%0d: data %h valid %b ready %b busy %b state %0d, expected %h %b %b %b %0d",
                     i, out_data, out_valid, in_ready, busy, dbg_state, exp_data(), exp_valid(), m_ready(), m_busy(), m_state());
         end
      end
`ifdef ARRAY_EDGE_FEEDER_STATS_EN
      checks++;
      if (stat_beats !== 32'(m_beats) || stat_bubbles !== 32'(m_bubbles)) begin
         errors++;
         $display("FAIL stats: beats %0d bubbles %0d, expected %0d %0d", stat_beats, stat_bubbles, m_beats, m_bubbles);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_bubbles();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/array_edge_feeder.md
Name: array_edge_feeder

Overview:
- Drives the left-edge data inputs of a systolic PE array row set (one 16-bit lane per array row). It is the transmitting end of the PE left→right data path.
- Accepts one row-vector per valid/ready handshake and applies diagonal skew: row r is delayed r extra cycles, so the wavefront enters the array aligned with PE register timing.
- Ends each stream with a drain phase that pushes the skew pipeline empty, so the last vector fully enters the array.

Parameters:
- ROWS, 4, number of array rows (lanes); ≥2
- DATA_W, 16, lane width; matches PE io_left_data width

Ports:
- clk  input  1  clock; all logic on posedge
- reset  input  1  synchronous, active-high
- in_valid  input  1  upstream vector valid
- in_ready  output  1  feeder can accept a vector this cycle
- in_data  input  ROWS*DATA_W  lane r = bits [r*DATA_W +: DATA_W]
- in_last  input  1  marks final vector of a stream; qualified by handshake
- out_data  output  ROWS*DATA_W  lane r drives io_left_data of array row r
- out_valid  output  ROWS  bit r = lane r carries real data (not a bubble)
- busy  output  1  state != IDLE

Behaviour:
- One clock domain. Reset is synchronous and active-high, on clk/reset as named above (fixed).
- Accept = in_valid && in_ready. in_ready = (state != DRAIN); it is combinational from state only, never from in_valid.
- The skew pipeline advances every cycle and never stalls. With no accept, a bubble enters: data 0, valid 0.
- Lane r is a chain of r+1 registers. Stage 0 loads in_data lane r (or 0) and the accept flag.
- Latency from accept at cycle t: lane r data appears at out_data/out_valid in cycle t+1+r. Lane 0 therefore has 1-cycle latency, and lane ROWS-1 has ROWS-cycle latency.
- Back-to-back accepts yield contiguous valid beats on every lane. Bubbles propagate with the same skew.
- FSM states:
  - IDLE: in_ready=1. Accept without in_last → STREAM. Accept with in_last → DRAIN. No accept → stay.
  - STREAM: in_ready=1. Accept with in_last → DRAIN. Otherwise stay, inserting a bubble on cycles with no accept.
  - DRAIN: in_ready=0. drain_cnt loads ROWS-1 on entry and decrements each cycle. At drain_cnt==1 → IDLE. drain_cnt is $clog2(ROWS) bits wide.
- A single-vector stream (IDLE accept with in_last) is legal.
- busy=1 from the cycle after the first accept until the FSM is back in IDLE. Last valid beat leaves lane ROWS-1 on the same cycle busy falls.
- in_valid during DRAIN: not accepted; upstream holds it (standard valid/ready; in_data must stay stable while in_valid && !in_ready).
- Reset (any state, including mid-stream or mid-drain): state=IDLE, drain_cnt=0, all skew registers data=0 and valid=0. Therefore out_data=0, out_valid=0, busy=0, and in_ready=1 on the first cycle after reset. In-flight vectors are discarded.
- No arithmetic on data; lanes pass through bit-exact.

Optional Feature:
- Macro ARRAY_EDGE_FEEDER_STATS_EN.
- Defined: add outputs stat_beats[31:0] (count of accepts) and stat_bubbles[31:0] (cycles in STREAM with no accept).
  - Both clear on reset and wrap modulo 2^32.
  - A beat accepted in IDLE counts as a beat.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package array_pkg holds:
  - DATA_W default (16)
  - ROWS default (4)
  - FSM enum feeder_state_t {IDLE, STREAM, DRAIN}
- Sub-module skew_line (params DEPTH, DATA_W): a DEPTH-stage data+valid shift register with synchronous reset.
  - Instantiated once per lane with DEPTH=r+1 via generate.
  - The FSM stays in the top.

Test Plan:
- Reset then idle: after reset, out_data=0, out_valid=0, in_ready=1, busy=0; hold in_valid=0 for 10 cycles and outputs stay 0.
- Single vector {lane3..0}=0x0004,0x0003,0x0002,0x0001 with in_last, accepted cycle t:
  - lane0=0x0001 at t+1, lane1=0x0002 at t+2, lane2=0x0003 at t+3, lane3=0x0004 at t+4, each with out_valid bit set for exactly one cycle.
  - in_ready=0 at t+1..t+3 and 1 at t+4; busy falls at t+4.
- Back-to-back stream: 5 vectors whose lane r = 0x10*k+r (k=0..4), last on k=4.
  - Each lane shows 5 consecutive valid beats, starting r+1 cycles after the first accept.
  - DRAIN lasts 3 cycles.
- Bubble insertion: 3-vector stream with in_valid low for 2 cycles between vectors 1 and 2. Every lane shows a 2-cycle gap (out_valid=0, data 0) at the skewed position.
- Backpressure: assert in_valid with a new vector during DRAIN. It is not accepted until the IDLE cycle, is then accepted, and in_data stays stable throughout.
- Reset mid-stream: assert reset at t+2 after 2 accepts. The next cycle all out_valid=0, out_data=0, state=IDLE, and no stale beats emerge afterwards.
